// File: rtl/to_udp_ctrl_pkg.sv
// Shared types and constants for the app-to-UDP NoC adapter control.
package to_udp_ctrl_pkg;

    // Datapath output mux select
    typedef enum logic [1:0] {
        HDR_SEL  = 2'd0,
        META_SEL = 2'd1,
        DATA_SEL = 2'd2
    } out_sel_t;

    // Control FSM states
    typedef enum logic [1:0] {
        READY     = 2'd0,
        HDR_OUT   = 2'd1,
        META_OUT  = 2'd2,
        DATA_PASS = 2'd3
    } state_t;

    localparam int unsigned NOC_DATA_W_DFLT = 512;
    localparam int unsigned BPF_DFLT        = NOC_DATA_W_DFLT / 8;
    localparam int unsigned BPF_LOG2_DFLT   = $clog2(BPF_DFLT);

    // log2 of bytes per flit for a given flit width
    function automatic int unsigned bpf_log2(input int unsigned noc_data_w);
        return $clog2(noc_data_w / 8);
    endfunction

endpackage

// File: rtl/to_udp_flit_cnt.sv
// Data-flit count for one message: ceil(len / BPF), loaded on meta accept and
// decremented per data handshake.
module to_udp_flit_cnt
    import to_udp_ctrl_pkg::*;
#(
    parameter int unsigned NOC_DATA_W = NOC_DATA_W_DFLT,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FLIT_CNT_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_W-1:0]      len,
    input  logic                  load,
    input  logic                  dec,
    output logic [FLIT_CNT_W-1:0] data_flits,
    output logic                  rem_is_one,
    output logic                  rem_zero
);

    localparam int unsigned BPF      = NOC_DATA_W / 8;
    localparam int unsigned BPF_LOG2 = bpf_log2(NOC_DATA_W);

    logic [LEN_W:0]          len_rnd;
    logic [LEN_W:0]          quot;
    logic [FLIT_CNT_W-1:0]   rem_d;
    logic [FLIT_CNT_W-1:0]   rem_q;
    logic                    unused_quot;

    // Ceil-divide at LEN_W+1 bits so the maximum length cannot wrap
    always_comb begin
        len_rnd    = {1'b0, len} + (LEN_W+1)'(BPF - 1);
        quot       = len_rnd >> BPF_LOG2;
        data_flits = quot[FLIT_CNT_W-1:0];
    end

    assign unused_quot = ^quot;

    // Remaining-flit counter next value: load wins over decrement
    always_comb begin
        rem_d = rem_q;
        if (load) begin
            rem_d = data_flits;
        end else if (dec) begin
            rem_d = rem_q - FLIT_CNT_W'(1);
        end
    end

    // Remaining-flit counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem_is_one = (rem_q == FLIT_CNT_W'(1));
    assign rem_zero   = (rem_q == '0);

endmodule

// File: rtl/to_udp_ctrl.sv
// Control FSM for the app-to-UDP NoC adapter: emits header, metadata, then
// payload flits, steering an external datapath.
// Optional build macro: TO_UDP_CTRL_LAST_CHECK_EN (sticky last/length check).
module to_udp_ctrl
    import to_udp_ctrl_pkg::*;
#(
    parameter int unsigned NOC_DATA_W = NOC_DATA_W_DFLT,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FLIT_CNT_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_to_udp_meta_val,
    output logic                  to_udp_src_meta_rdy,
    input  logic [LEN_W-1:0]      src_to_udp_meta_len,
    input  logic                  src_to_udp_data_val,
    input  logic                  src_to_udp_data_last,
    output logic                  to_udp_src_data_rdy,
    output logic                  to_udp_noc_vrtoc_val,
    input  logic                  noc_vrtoc_to_udp_rdy,
    output logic                  ctrl_datap_store_meta,
    output logic [1:0]            ctrl_datap_out_sel,
    output logic [FLIT_CNT_W-1:0] ctrl_datap_msg_flits,
    output logic                  ctrl_datap_err
);

    state_t                  state_d, state_q;
    out_sel_t                sel_d, sel_q;
    logic                    meta_rdy_d, meta_rdy_q;
    logic                    store_meta_d, store_meta_q;
    logic                    hdr_val_d, hdr_val_q;
    logic [FLIT_CNT_W-1:0]   msg_flits_d, msg_flits_q;
    logic                    cnt_load;
    logic                    cnt_dec;
    logic                    in_data;
    logic                    data_hs;
    logic [FLIT_CNT_W-1:0]   data_flits;
    logic                    rem_is_one;
    logic                    rem_zero;

    to_udp_flit_cnt #(
        .NOC_DATA_W (NOC_DATA_W),
        .LEN_W      (LEN_W),
        .FLIT_CNT_W (FLIT_CNT_W)
    ) u_flit_cnt (
        .clk        (clk),
        .rst        (rst),
        .len        (src_to_udp_meta_len),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .data_flits (data_flits),
        .rem_is_one (rem_is_one),
        .rem_zero   (rem_zero)
    );

    // Payload phase is a pure pass-through between source and NoC
    assign in_data              = (state_q == DATA_PASS);
    assign data_hs              = in_data && src_to_udp_data_val && noc_vrtoc_to_udp_rdy;
    assign to_udp_noc_vrtoc_val = in_data ? src_to_udp_data_val : hdr_val_q;
    assign to_udp_src_data_rdy  = in_data && noc_vrtoc_to_udp_rdy;
    assign to_udp_src_meta_rdy  = meta_rdy_q;
    assign ctrl_datap_store_meta = store_meta_q;
    assign ctrl_datap_out_sel   = sel_q;
    assign ctrl_datap_msg_flits = msg_flits_q;

    // Next state and next registered outputs; registered outputs are computed
    // for the state being entered so they line up with it
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        meta_rdy_d   = meta_rdy_q;
        store_meta_d = store_meta_q;
        hdr_val_d    = hdr_val_q;
        msg_flits_d  = msg_flits_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        case (state_q)
            READY: begin
                meta_rdy_d   = 1'b1;
                store_meta_d = 1'b1;
                hdr_val_d    = 1'b0;
                sel_d        = HDR_SEL;
                if (meta_rdy_q && src_to_udp_meta_val) begin
                    cnt_load     = 1'b1;
                    msg_flits_d  = data_flits + FLIT_CNT_W'(1);
                    state_d      = HDR_OUT;
                    meta_rdy_d   = 1'b0;
                    store_meta_d = 1'b0;
                    hdr_val_d    = 1'b1;
                end
            end
            HDR_OUT: begin
                if (noc_vrtoc_to_udp_rdy) begin
                    state_d = META_OUT;
                    sel_d   = META_SEL;
                end
            end
            META_OUT: begin
                if (noc_vrtoc_to_udp_rdy) begin
                    hdr_val_d = 1'b0;
                    if (!rem_zero) begin
                        state_d = DATA_PASS;
                        sel_d   = DATA_SEL;
                    end else begin
                        state_d      = READY;
                        sel_d        = HDR_SEL;
                        meta_rdy_d   = 1'b1;
                        store_meta_d = 1'b1;
                    end
                end
            end
            DATA_PASS: begin
                if (data_hs) begin
                    cnt_dec = 1'b1;
                    if (rem_is_one) begin
                        state_d      = READY;
                        sel_d        = HDR_SEL;
                        meta_rdy_d   = 1'b1;
                        store_meta_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d      = state_t'('x);
                sel_d        = out_sel_t'('x);
                meta_rdy_d   = 1'bx;
                store_meta_d = 1'bx;
                hdr_val_d    = 1'bx;
                msg_flits_d  = 'x;
                cnt_load     = 1'bx;
                cnt_dec      = 1'bx;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= READY;
            sel_q        <= HDR_SEL;
            meta_rdy_q   <= 1'b0;
            store_meta_q <= 1'b0;
            hdr_val_q    <= 1'b0;
            msg_flits_q  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            meta_rdy_q   <= meta_rdy_d;
            store_meta_q <= store_meta_d;
            hdr_val_q    <= hdr_val_d;
            msg_flits_q  <= msg_flits_d;
        end
    end

`ifdef TO_UDP_CTRL_LAST_CHECK_EN
    logic err_d, err_q;

    // Sticky flag: source last marker disagrees with counter-based framing
    always_comb begin
        err_d = err_q | (data_hs && (src_to_udp_data_last != rem_is_one));
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ctrl_datap_err = err_q;
`else
    logic unused_last;

    assign unused_last    = src_to_udp_data_last;
    assign ctrl_datap_err = 1'b0;
`endif

endmodule

// File: tb/tb_to_udp_ctrl.sv
// Scoreboard bench for to_udp_ctrl: expected NoC flits are queued per message
// and popped on each NoC handshake.
module tb_to_udp_ctrl;

    localparam int NOC_DATA_W = 512;
    localparam int LEN_W      = 16;
    localparam int FLIT_CNT_W = 11;
    localparam int BPF        = NOC_DATA_W / 8;

    localparam logic [1:0] S_HDR  = 2'd0;
    localparam logic [1:0] S_META = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

`ifdef TO_UDP_CTRL_LAST_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  meta_val;
    logic                  meta_rdy;
    logic [LEN_W-1:0]      meta_len;
    logic                  data_val;
    logic                  data_last;
    logic                  data_rdy;
    logic                  noc_val;
    logic                  noc_rdy;
    logic                  store_meta;
    logic [1:0]            out_sel;
    logic [FLIT_CNT_W-1:0] msg_flits;
    logic                  err;

    always #5 clk = ~clk;

    to_udp_ctrl #(
        .NOC_DATA_W (NOC_DATA_W),
        .LEN_W      (LEN_W),
        .FLIT_CNT_W (FLIT_CNT_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .src_to_udp_meta_val  (meta_val),
        .to_udp_src_meta_rdy  (meta_rdy),
        .src_to_udp_meta_len  (meta_len),
        .src_to_udp_data_val  (data_val),
        .src_to_udp_data_last (data_last),
        .to_udp_src_data_rdy  (data_rdy),
        .to_udp_noc_vrtoc_val (noc_val),
        .noc_vrtoc_to_udp_rdy (noc_rdy),
        .ctrl_datap_store_meta(store_meta),
        .ctrl_datap_out_sel   (out_sel),
        .ctrl_datap_msg_flits (msg_flits),
        .ctrl_datap_err       (err)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] flits;
    } exp_t;

    exp_t sbq[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   noc_cnt, d_cnt, meta_cnt, stall_h, stall_d, first_cyc, last_cyc;
    bit   prev_stall;
    logic [1:0] prev_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Samples on the falling edge; handshakes seen here commit on the next rising edge
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_val", 32'(noc_val), 32'd1);
                    check("hold_sel", 32'(out_sel), 32'(prev_sel));
                end
                prev_stall = noc_val && !noc_rdy;
                prev_sel   = out_sel;
                if (noc_val && !noc_rdy) begin
                    if (noc_cnt == 0 && stall_h > 0) stall_h--;
                    else if (noc_cnt == 2 && stall_d > 0) stall_d--;
                end
                if (meta_val && meta_rdy) meta_cnt++;
                if (data_val && data_rdy) d_cnt++;
                if (noc_val && noc_rdy) begin
                    if (noc_cnt == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    noc_cnt++;
                    check("sb_avail", 32'(sbq.size() != 0), 32'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check("sel", 32'(out_sel), 32'(e.sel));
                        check("msg_flits", 32'(msg_flits), e.flits);
                        if (e.sel == S_DATA) check("drdy", 32'(data_rdy), 32'd1);
                    end
                end
            end
        end
    endtask

    // One message: hs/ds = NoC stall cycles on HDR / first data flit,
    // last_idx = data flit carrying last, abort_at >= 0 resets after that many data flits
    task automatic run_msg(input int len, input int hs, input int ds, input int last_idx,
                           input int abort_at);
        int   n;
        exp_t e;
        n = (len + BPF - 1) / BPF;
        e.flits = 32'(n + 1);
        e.sel = S_HDR;  sbq.push_back(e);
        e.sel = S_META; sbq.push_back(e);
        for (int i = 0; i < n; i++) begin
            e.sel = S_DATA; sbq.push_back(e);
        end
        noc_cnt = 0; d_cnt = 0; meta_cnt = 0; stall_h = hs; stall_d = ds;
        meta_len  = LEN_W'(len);
        meta_val  = 1'b1;
        data_val  = 1'b1;
        data_last = (last_idx == 0);
        noc_rdy   = !(stall_h > 0);
        for (int c = 0; c < 4 * n + hs + ds + 40; c++) begin
            if (noc_cnt >= n + 2) break;
            if (abort_at >= 0 && d_cnt >= abort_at) break;
            @(posedge clk); #1;
            if (meta_cnt != 0) meta_val = 1'b0;
            data_last = (d_cnt == last_idx);
            noc_rdy   = !((noc_cnt == 0 && stall_h > 0) || (noc_cnt == 2 && stall_d > 0));
        end
        meta_val = 1'b0;
        if (abort_at >= 0) begin
            check("abort_reached", 32'(d_cnt), 32'(abort_at));
            check("err_sticky", 32'(err), 32'(ERR_EN));
            check("pre_rst_val", 32'(noc_val), 32'd1);
            #2 rst = 1'b1;
            #1;
            check("arst_val", 32'(noc_val), 32'd0);
            check("arst_drdy", 32'(data_rdy), 32'd0);
            check("arst_meta_rdy", 32'(meta_rdy), 32'd0);
            check("arst_store", 32'(store_meta), 32'd0);
            check("arst_sel", 32'(out_sel), 32'd0);
            check("arst_flits", 32'(msg_flits), 32'd0);
            check("arst_err", 32'(err), 32'd0);
            data_val = 1'b0; data_last = 1'b0; noc_rdy = 1'b1;
            sbq.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            return;
        end
        data_val = 1'b0; data_last = 1'b0; noc_rdy = 1'b1;
        check("noc_hs", 32'(noc_cnt), 32'(n + 2));
        check("data_hs", 32'(d_cnt), 32'(n));
        check("meta_hs", 32'(meta_cnt), 32'd1);
        check("sb_left", 32'(sbq.size()), 32'd0);
        sbq.delete();
        check("span", 32'(last_cyc - first_cyc), 32'(n + 1 + (n > 0 ? ds : 0)));
        @(negedge clk);
        check("ready_after", 32'(meta_rdy), 32'd1);
        check("sel_after", 32'(out_sel), 32'(S_HDR));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int len, hs, ds, n;
        rst = 1'b1; meta_val = 1'b0; meta_len = '0; data_val = 1'b0;
        data_last = 1'b0; noc_rdy = 1'b1;
        noc_cnt = 0; d_cnt = 0; meta_cnt = 0; stall_h = 0; stall_d = 0;
        first_cyc = 0; last_cyc = 0; prev_stall = 1'b0; prev_sel = '0;
        fork
            monitor();
        join_none

        #12;
        check("rst_meta_rdy", 32'(meta_rdy), 32'd0);
        check("rst_store", 32'(store_meta), 32'd0);
        check("rst_val", 32'(noc_val), 32'd0);
        check("rst_drdy", 32'(data_rdy), 32'd0);
        check("rst_sel", 32'(out_sel), 32'd0);
        check("rst_flits", 32'(msg_flits), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        check("idle_meta_rdy", 32'(meta_rdy), 32'd1);
        check("idle_store", 32'(store_meta), 32'd1);

        run_msg(128, 0, 0, 1, -1);
        idle(1);
        run_msg(0, 0, 0, -1, -1);
        idle(1);
        run_msg(65, 3, 2, 1, -1);
        idle(1);
        run_msg(65535, 0, 0, 1023, -1);
        idle(1);

        check("err_pre", 32'(err), 32'd0);
        run_msg(192, 0, 0, 1, -1);
        check("err_set", 32'(err), 32'(ERR_EN));
        idle(3);
        check("err_hold", 32'(err), 32'(ERR_EN));

        for (int k = 0; k < 4; k++) begin
            len = int'($urandom_range(0, 1500));
            hs  = int'($urandom_range(0, 2));
            ds  = int'($urandom_range(0, 2));
            n   = (len + BPF - 1) / BPF;
            run_msg(len, hs, ds, n - 1, -1);
            idle(1);
        end

        run_msg(256, 0, 0, 3, 1);
        run_msg(64, 0, 0, 0, -1);
        check("err_cleared", 32'(err), 32'd0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
